// File: rtl/pc_jump_seq_pkg.sv
// pc_jump_seq_pkg: shared state encoding, default vectors and next-pc select codes
package pc_jump_seq_pkg;
  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_e;
  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JR   = 3'd2,
    SEL_J    = 3'd3,
    SEL_EXC  = 3'd4,
    SEL_HOLD = 3'd5
  } sel_e;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;
  function automatic logic misaligned(input logic [31:0] a);
    return |a[1:0];
  endfunction
endpackage

// File: rtl/pc_jump_seq_jtf.sv
// jump_target_form: builds the J/JAL target from the PC+4 region and the shifted index
//   pc_plus4 : PC+4 of the ID instruction (only the top nibble selects the region)
//   jidx28   : instr[25:0] << 2
//   target   : {pc_plus4[31:28], jidx28}
module jump_target_form (
  input  logic [31:0] pc_plus4,
  input  logic [27:0] jidx28,
  output logic [31:0] target
);
  assign target = {pc_plus4[31:28], jidx28};
endmodule

// File: rtl/pc_jump_seq.sv
// pc_jump_seq: fetch PC sequencer arbitrating branch, JR, J, stall and misaligned-JR trap
//   clk, reset        : clock, async active-high reset
//   stall             : hold PC and IF/ID
//   id_jump/id_jidx28/id_pc_plus4 : J/JAL in ID and its target fields
//   id_jr/id_jr_target: JR/JALR in ID and forwarded rs
//   ex_br_taken/ex_br_target      : taken branch resolved in EX
//   pc, pc_plus4      : fetch address and its successor
//   if_flush, id_flush, exc       : combinational squash and trap pulses
//   bad_addr          : last misaligned JR target
//   redirect_cnt      : saturating count of RUN-state redirects
module pc_jump_seq
  import pc_jump_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             id_jump,
  input  logic [27:0]      id_jidx28,
  input  logic [31:0]      id_pc_plus4,
  input  logic             id_jr,
  input  logic [31:0]      id_jr_target,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             if_flush,
  output logic             id_flush,
  output logic             exc,
  output logic [31:0]      bad_addr,
  output logic [CNT_W-1:0] redirect_cnt
);
  state_e           state_q, state_d;
  sel_e             sel;
  logic [31:0]      pc_q, pc_d, bad_q, bad_d, j_target;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             if_fl, id_fl, exc_p;
  jump_target_form u_jtf (
    .pc_plus4 (id_pc_plus4),
    .jidx28   (id_jidx28),
    .target   (j_target)
  );
  // Priority: EX branch is older than anything in ID, so it beats stall and ID jumps.
  always_comb begin
    sel     = SEL_SEQ;
    state_d = state_q;
    bad_d   = bad_q;
    if_fl   = 1'b0;
    id_fl   = 1'b0;
    exc_p   = 1'b0;
    if (state_q == TRAP) begin
      state_d = RUN;
      exc_p   = 1'b1;
      if_fl   = 1'b1;
    end else if (ex_br_taken) begin
      sel   = SEL_BR;
      if_fl = 1'b1;
      id_fl = 1'b1;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (id_jr && misaligned(id_jr_target)) begin
      sel     = SEL_EXC;
      bad_d   = id_jr_target;
      if_fl   = 1'b1;
      state_d = TRAP;
    end else if (id_jr) begin
      sel   = SEL_JR;
      if_fl = 1'b1;
    end else if (id_jump) begin
      sel   = SEL_J;
      if_fl = 1'b1;
    end
  end
  // TRAP leaves pc at the vector and steps past it on exit; wrap at the top is silent.
  always_comb begin
    pc_d = sel == SEL_BR   ? ex_br_target :
           sel == SEL_JR   ? id_jr_target :
           sel == SEL_J    ? j_target     :
           sel == SEL_EXC  ? EXC_VECTOR   :
           sel == SEL_HOLD ? pc_q         : pc_q + 32'd4;
    cnt_d = (state_q == RUN && if_fl && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      bad_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end
  // Reset must silence the combinational pulses at once, not just at the next edge.
  assign if_flush     = if_fl & ~reset;
  assign id_flush     = id_fl & ~reset;
  assign exc          = exc_p & ~reset;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign bad_addr     = bad_q;
  assign redirect_cnt = cnt_q;
endmodule
